// File: rtl/mod_inverse_serial_pkg.sv
// Shared definitions for the serial modular inverter: FSM state encoding
// and the default operand width.
package mod_inverse_serial_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        HALVE_U,
        HALVE_V,
        SUB,
        FINISH
    } state_t;

endpackage

// File: rtl/mod_inverse_serial_sub.sv
// Modular subtract z = (x - y) mod p for operands already reduced into [0, p-1].
module mod_sub_p #(
    parameter int W = 4
) (
    input  logic [W:0]   x,
    input  logic [W:0]   y,
    input  logic [W-1:0] p,
    output logic [W:0]   z
);

    logic         w_borrow;
    logic [W:0]   w_diff;

    // Wrapping arithmetic at W+1 bits is exact because the true result fits in [0, p-1].
    assign w_borrow = (x < y);
    assign w_diff   = x - y;
    assign z        = w_borrow ? (w_diff + {1'b0, p}) : w_diff;

endmodule

// File: rtl/mod_inverse_serial.sv
// Serial binary extended-Euclid inverter: inv = a^-1 mod p, one FSM step per clock.
module mod_inverse_serial
    import mod_inverse_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         load,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] p,
    output logic [W-1:0] inv,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_t       r_state, w_state_next;
    logic [W-1:0] r_u, r_v, r_p, r_a, r_inv;
    logic [W-1:0] w_u_next, w_v_next, w_p_next, w_a_next, w_inv_next;
    logic [W:0]   r_x1, r_x2, w_x1_next, w_x2_next;
    logic         r_err, w_err_next;

    logic [W:0]       w_x1_plus, w_x2_plus, w_x1_half, w_x2_half;
    logic [1:0][W:0]  w_opnd;
    logic [1:0][W:0]  w_sub;
    logic             w_u_one, w_v_one, w_any_zero;

    // w_sub[0] = (x1 - x2) mod p, w_sub[1] = (x2 - x1) mod p
    assign w_opnd = {r_x2, r_x1};
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sub
            mod_sub_p #(.W(W)) u_sub (
                .x (w_opnd[gi]),
                .y (w_opnd[1-gi]),
                .p (r_p),
                .z (w_sub[gi])
            );
        end
    endgenerate

    // Halving mod p: odd values get p added first so the shift is exact.
    assign w_x1_plus  = r_x1[0] ? (r_x1 + {1'b0, r_p}) : r_x1;
    assign w_x2_plus  = r_x2[0] ? (r_x2 + {1'b0, r_p}) : r_x2;
    assign w_x1_half  = w_x1_plus >> 1;
    assign w_x2_half  = w_x2_plus >> 1;

    assign w_u_one    = (r_u == W'(1));
    assign w_v_one    = (r_v == W'(1));
    assign w_any_zero = (r_u == '0) || (r_v == '0);

    always_comb begin
        w_state_next = r_state;
        w_u_next     = r_u;
        w_v_next     = r_v;
        w_x1_next    = r_x1;
        w_x2_next    = r_x2;
        w_p_next     = r_p;
        w_a_next     = r_a;
        w_inv_next   = r_inv;
        w_err_next   = r_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_u_next     = a;
                    w_v_next     = p;
                    w_x1_next    = (W+1)'(1);
                    w_x2_next    = '0;
                    w_p_next     = p;
                    w_a_next     = a;
                    w_err_next   = 1'b0;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if ((r_a == '0) || (r_a >= r_p)) begin
                    w_err_next   = 1'b1;
                    w_inv_next   = '0;
                    w_state_next = FINISH;
                end else begin
                    w_state_next = HALVE_U;
                end
            end
            HALVE_U: begin
                // inv is loaded on the way into FINISH so it is already valid while done is high.
                if (w_u_one || w_v_one) begin
                    w_inv_next   = w_u_one ? r_x1[W-1:0] : r_x2[W-1:0];
                    w_state_next = FINISH;
                end else if (w_any_zero) begin
                    // Only reachable with a non-prime modulus sharing a factor with a.
                    w_err_next   = 1'b1;
                    w_inv_next   = '0;
                    w_state_next = FINISH;
                end else if (!r_u[0]) begin
                    w_u_next  = r_u >> 1;
                    w_x1_next = w_x1_half;
                end else begin
                    w_state_next = HALVE_V;
                end
            end
            HALVE_V: begin
                if (w_u_one || w_v_one) begin
                    w_inv_next   = w_u_one ? r_x1[W-1:0] : r_x2[W-1:0];
                    w_state_next = FINISH;
                end else if (w_any_zero) begin
                    w_err_next   = 1'b1;
                    w_inv_next   = '0;
                    w_state_next = FINISH;
                end else if (!r_v[0]) begin
                    w_v_next  = r_v >> 1;
                    w_x2_next = w_x2_half;
                end else begin
                    w_state_next = SUB;
                end
            end
            SUB: begin
                if (r_u >= r_v) begin
                    w_u_next  = r_u - r_v;
                    w_x1_next = w_sub[0];
                end else begin
                    w_v_next  = r_v - r_u;
                    w_x2_next = w_sub[1];
                end
                w_state_next = HALVE_U;
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (load) begin
            r_state <= IDLE;
            r_u     <= '0;
            r_v     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_p     <= '0;
            r_a     <= '0;
            r_inv   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_u     <= w_u_next;
            r_v     <= w_v_next;
            r_x1    <= w_x1_next;
            r_x2    <= w_x2_next;
            r_p     <= w_p_next;
            r_a     <= w_a_next;
            r_inv   <= w_inv_next;
            r_err   <= w_err_next;
        end
    end

    assign inv  = r_inv;
    assign err  = r_err;
    assign busy = (r_state != IDLE);
    assign done = (r_state == FINISH);

endmodule

// File: tb/tb_mod_inverse_serial.sv
// Directed self-checking bench for mod_inverse_serial (W=4) with hand-computed inverses.
module tb_mod_inverse_serial;

    localparam int W = 4;

    logic         clk;
    logic         load;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] p;
    logic [W-1:0] inv;
    logic         busy;
    logic         done;
    logic         err;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    int prev_inv   = 0;

    mod_inverse_serial #(.W(W)) dut (
        .clk   (clk),
        .load  (load),
        .start (start),
        .a     (a),
        .p     (p),
        .inv   (inv),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int ai, input int pi);
        @(negedge clk);
        a     = W'(ai);
        p     = W'(pi);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input int ai, input int pi,
                          input int exp_inv, input int exp_err, input int budget);
        int lat;
        start_op(ai, pi);
        check({tag, "/busy"}, 32'(busy), 1);
        check({tag, "/hold_inv"}, 32'(inv), 32'(prev_inv));
        check({tag, "/err_clr"}, 32'(err), 0);
        wait_done(budget, lat);
        check({tag, "/done_in_budget"}, 32'(done), 1);
        check({tag, "/inv"}, 32'(inv), 32'(exp_inv));
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        $display("op %s a=%0d p=%0d inv=%0d err=%0d latency=%0d", tag, ai, pi, inv, err, lat);
        prev_inv = exp_inv;
        @(negedge clk);
        check({tag, "/done_pulse"}, 32'(done), 0);
        check({tag, "/idle"}, 32'(busy), 0);
    endtask

    localparam int INV13 [12] = '{1, 7, 9, 10, 8, 11, 2, 5, 3, 4, 6, 12};

    initial begin
        int lat;
        int dc0;

        // Reset, with a start held alongside load that must be dropped.
        load  = 1'b1;
        start = 1'b1;
        a     = 4'd3;
        p     = 4'd11;
        repeat (3) @(negedge clk);
        check("reset/busy", 32'(busy), 0);
        check("reset/done", 32'(done), 0);
        check("reset/err", 32'(err), 0);
        check("reset/inv", 32'(inv), 0);
        load  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset/start_with_load_ignored", 32'(busy), 0);

        run_op("a3p11", 3, 11, 4, 0, 20);
        run_op("a2p13", 2, 13, 7, 0, 20);
        run_op("a10p11", 10, 11, 10, 0, 20);
        run_op("a1p13", 1, 13, 1, 0, 20);
        run_op("a0p11", 0, 11, 0, 1, 3);
        run_op("a12p11", 12, 11, 0, 1, 3);
        run_op("a7p11", 7, 11, 8, 0, 20);

        // Abort with load three cycles into an operation.
        dc0 = done_count;
        start_op(5, 13);
        repeat (2) @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        check("abort/busy", 32'(busy), 0);
        check("abort/done", 32'(done), 0);
        check("abort/inv", 32'(inv), 0);
        check("abort/err", 32'(err), 0);
        load = 1'b0;
        prev_inv = 0;
        repeat (25) @(negedge clk);
        check("abort/no_done_pulse", 32'(done_count - dc0), 0);
        $display("op abort a=5 p=13 busy=%0d done_pulses=%0d", busy, done_count - dc0);
        run_op("after_abort_a5p13", 5, 13, 8, 0, 20);

        // Second start while busy must be ignored.
        dc0 = done_count;
        start_op(3, 11);
        @(negedge clk);
        a     = 4'd7;
        p     = 4'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, lat);
        check("repulse/done_in_budget", 32'(done), 1);
        check("repulse/inv", 32'(inv), 4);
        check("repulse/err", 32'(err), 0);
        repeat (25) @(negedge clk);
        check("repulse/one_done", 32'(done_count - dc0), 1);
        check("repulse/idle", 32'(busy), 0);
        $display("op repulse a=3 p=11 inv=%0d err=%0d done_pulses=%0d", inv, err, done_count - dc0);
        prev_inv = 4;

        // Every nonzero residue mod 13.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("sweep13_a%0d", i + 1), i + 1, 13, INV13[i], 0, 4 * W + 4);
            check($sformatf("sweep13_a%0d/product", i + 1), 32'((int'(inv) * (i + 1)) % 13), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_inverse_serial.md
MOD_INVERSE_SERIAL -- requirements
Module: mod_inverse_serial

Interface
REQ-001 SHALL have parameter: W, default 4, operand/modulus width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: load  input  1  reset, synchronous and active-high; clears all state.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin an inversion; sampled only in IDLE.
REQ-005 SHALL have port: a  input  W  operand to invert; sampled on the accepted start cycle.
REQ-006 SHALL have port: p  input  W  odd prime modulus; sampled on the accepted start cycle.
REQ-007 SHALL have port: inv  output  W  result a^-1 mod p; valid from the done pulse until the next accepted start.
REQ-008 SHALL have port: busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when inv/err are final.
REQ-010 SHALL have port: err  output  1  set with done when a==0 or a>=p; held until the next accepted start.

Function
REQ-011 SHALL implement the binary extended Euclidean algorithm over GF(p); registers u, v (W bits) and x1, x2 (W+1 bits internal).
REQ-012 SHALL use FSM states IDLE, CHECK, HALVE_U, HALVE_V, SUB, FINISH; exactly one state step per clock.
REQ-013 IDLE: on start=1, capture u=a, v=p, x1=1, x2=0, latch p, clear err, go CHECK; start while not IDLE is ignored.
REQ-014 CHECK: if latched a==0 or a>=p, set err, inv=0, go FINISH; else go HALVE_U.
REQ-015 HALVE_U: if u==1 or v==1 go FINISH; if u even, u=u>>1 and x1 = x1 even ? x1>>1 : (x1+p)>>1, stay; else go HALVE_V.
REQ-016 HALVE_V: same rule applied to v/x2; when v odd go SUB.
REQ-017 SUB: if u>=v, u=u-v and x1=(x1-x2) mod p; else v=v-u and x2=(x2-x1) mod p; then go HALVE_U.
REQ-018 Modular subtract SHALL add p when the raw difference is negative; results stay in [0,p-1].
REQ-019 x1+p SHALL be computed at W+1 bits with no overflow loss.
REQ-020 FINISH: inv = (u==1) ? x1 : x2 (unless err), pulse done for one cycle, return IDLE.
REQ-021 Latency from accepted start to done SHALL not exceed 4*W+4 cycles for any valid input.
REQ-022 a==1 SHALL yield inv=1 with err=0.
REQ-023 Outputs inv and err SHALL hold stable while busy=1 from a previous result, updating only in FINISH or on accepted start (err clear only).

Reset
REQ-024 load=1 SHALL, on the next rising edge, force IDLE, busy=0, done=0, err=0, inv=0, u=v=x1=x2=0, regardless of state.
REQ-025 load asserted mid-operation SHALL abort without a done pulse; start in the same cycle as load is ignored.
REQ-026 The first start after load deasserts SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration and the default W constant.
REQ-028 Modular subtract SHALL be a sub-module mod_sub_p (inputs x, y, p; output (x-y) mod p), instantiated twice or muxed.
REQ-029 All registers SHALL be in one clocked process; no latches, no second clock.

Verification
REQ-030 a=3, p=11, start pulse -> done within 20 cycles, inv=4, err=0.
REQ-031 a=2, p=13 -> inv=7; a=10, p=11 -> inv=10; a=1, p=13 -> inv=1; all err=0.
REQ-032 a=0, p=11 -> done within 3 cycles, err=1, inv=0; a=12, p=11 -> err=1.
REQ-033 load raised 3 cycles after start with a=5, p=13 -> no done pulse, busy=0 next cycle; new start a=5 -> inv=8.
REQ-034 start re-pulsed while busy with a=7 -> ignored; original operand result delivered, exactly one done pulse.
REQ-035 Exhaustive sweep p=13, a=1..12 -> inv*a mod 13 == 1 for every a, each within 4*W+4 cycles.
